// File: rtl/jt6295_ctrl_q.sv
// Command decoder and phrase-table fetcher for the ADPCM player: CPU byte writes become
// queued start requests and stop bits. Optional ROM banking is enabled with JT6295_BANK_EN.
module jt6295_ctrl_q #(
  parameter int CH  = 4,
  parameter int PHW = 7,
  parameter int AW  = 18,
  parameter int QD  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen4,
  input  logic           wrn,
  input  logic [7:0]     din,
`ifdef JT6295_BANK_EN
  input  logic [3:0]     bank,
  output logic [PHW+6:0] rom_addr,
`else
  output logic [PHW+2:0] rom_addr,
`endif
  input  logic [7:0]     rom_data,
  input  logic           rom_ok,
  output logic [AW-1:0]  start_addr,
  output logic [AW-1:0]  stop_addr,
  output logic [3:0]     att,
  output logic [CH-1:0]  start,
  output logic [CH-1:0]  stop,
  input  logic [CH-1:0]  busy,
  input  logic [CH-1:0]  ack,
  output logic           qfull,
  output logic           ovf
);

  localparam int NG = CH / 4;
  localparam int QW = (QD > 1) ? $clog2(QD) : 1;
  localparam int RW = $bits(rom_addr);
  localparam logic [QW:0] QDV = (QW+1)'(QD);
`ifdef JT6295_BANK_EN
  localparam int AB = AW - 4;  // top four address bits come from the bank
`else
  localparam int AB = AW;
`endif

  typedef struct packed {
    logic [PHW-1:0] phrase;
    logic [CH-1:0]  mask;
    logic [3:0]     att;
`ifdef JT6295_BANK_EN
    logic [3:0]     bank;
`endif
  } entry_t;

  typedef enum logic [1:0] {IDLE, READ, LOAD, HOLD} state_t;

  function automatic logic [CH-1:0] expand(input logic [3:0] nib, input logic [2:0] g);
    logic [CH-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++)
      if (i / 4 == int'(g)) r[i] = nib[i % 4];
    return r;
  endfunction

  function automatic logic [RW-1:0] rom_a(input entry_t e, input logic [2:0] i);
`ifdef JT6295_BANK_EN
    return {e.bank, e.phrase, i};
`else
    return {e.phrase, i};
`endif
  endfunction

  // ---------------- CPU byte decoder ----------------
  logic           wrn_l, cmd, pend_v;
  logic [PHW-1:0] phrase_r, pend_phrase;
  logic [2:0]     grp;
  logic [CH-1:0]  pend_mask, stop_set, stop_nxt;
  logic [3:0]     pend_att;
  logic           wr_ev;

  assign wr_ev = ~wrn & wrn_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrn_l       <= 1'b1;
      cmd         <= 1'b0;
      phrase_r    <= '0;
      grp         <= '0;
      pend_v      <= 1'b0;
      pend_phrase <= '0;
      pend_mask   <= '0;
      pend_att    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every block samples pre-edge values.
      wrn_l  <= wrn;
      pend_v <= 1'b0;
      if (wr_ev) begin
        if (cmd) begin
          cmd         <= 1'b0;
          pend_v      <= 1'b1;
          pend_phrase <= phrase_r;
          pend_mask   <= expand(din[7:4], grp);
          pend_att    <= din[3:0];
        end else if (din[7]) begin
          phrase_r <= PHW'(din[6:0]);
          cmd      <= 1'b1;
        end else if (din[6:3] == 4'd0) begin
          grp <= 3'(din[2:0] % NG);
        end
      end
    end
  end

  // A stop write is applied last so it wins over the cen4 retire in the same cycle
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    stop_set = '0;
    if (wr_ev && !cmd && !din[7] && din[6:3] != 4'd0) stop_set = expand(din[6:3], grp);
    stop_nxt = stop;
    if (cen4)   stop_nxt = stop_nxt & busy;
    if (pend_v) stop_nxt = stop_nxt & ~pend_mask;
    stop_nxt = stop_nxt | stop_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stop <= '0;
    else     stop <= stop_nxt;
  end

  // ---------------- start-request FIFO ----------------
  entry_t        mem [QD];
  entry_t        push_e, next_e;
  logic [QW-1:0] wp, rp;
  logic [QW:0]   cnt;
  logic          take, pop, bypass, push, drop;
  state_t        state;

  always_comb begin
    push_e        = '0;
    push_e.phrase = pend_phrase;
    push_e.mask   = pend_mask;
    push_e.att    = pend_att;
`ifdef JT6295_BANK_EN
    push_e.bank   = bank;
`endif
  end

  // An empty FIFO hands the pending entry straight to the fetcher
  assign qfull  = (cnt == QDV);
  assign take   = (state == IDLE) && (cnt != '0 || pend_v);
  assign pop    = take && (cnt != '0);
  assign bypass = take && (cnt == '0);
  assign push   = pend_v && !bypass && (!qfull || pop);
  assign drop   = pend_v && qfull && !pop;
  assign next_e = bypass ? push_e : mem[rp];

  // NOTE: the storage array has no reset; emptiness is tracked by cnt, which is reset.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      cnt <= cnt + (QW+1)'(push) - (QW+1)'(pop);
      if (drop) ovf <= 1'b1;
    end
  end

  // ---------------- phrase-table fetcher ----------------
  entry_t        cur;
  logic [2:0]    idx;
  logic          ign;
  logic [AB-1:0] sbuf, pbuf;
  logic [CH-1:0] start_nxt;

  assign start_nxt = start & ~ack & ~stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      idx        <= '0;
      ign        <= 1'b0;
      rom_addr   <= '0;
      sbuf       <= '0;
      pbuf       <= '0;
      start      <= '0;
      start_addr <= '0;
      stop_addr  <= '0;
      att        <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          cur      <= next_e;
          idx      <= '0;
          ign      <= 1'b1;
          rom_addr <= rom_a(next_e, 3'd0);
          state    <= READ;
        end
        READ: begin
          // The byte in the cycle right after an address change is never trusted
          if (ign) ign <= 1'b0;
          else if (rom_ok) begin
            if (idx < 3'd3) sbuf <= {sbuf[AB-9:0], rom_data};
            else            pbuf <= {pbuf[AB-9:0], rom_data};
            if (idx == 3'd5) state <= LOAD;
            else begin
              idx      <= idx + 3'd1;
              ign      <= 1'b1;
              rom_addr <= rom_a(cur, idx + 3'd1);
            end
          end
        end
        LOAD: begin
`ifdef JT6295_BANK_EN
          start_addr <= {cur.bank, sbuf};
          stop_addr  <= {cur.bank, pbuf};
`else
          start_addr <= sbuf;
          stop_addr  <= pbuf;
`endif
          att   <= cur.att;
          start <= cur.mask;
          state <= HOLD;
        end
        HOLD: begin
          start <= start_nxt;
          if (start_nxt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt6295_ctrl_q.sv
// Randomized self-checking bench for jt6295_ctrl_q (CH=8 so group selection is exercised).
module tb_jt6295_ctrl_q;
  localparam int CH = 8, PHW = 7, AW = 18, QD = 2;

  logic           clk = 1'b0, rst = 1'b1, cen4 = 1'b0, wrn = 1'b1;
  logic [7:0]     din = '0;
  logic [PHW+2:0] rom_addr;
  logic [7:0]     rom_data = '0;
  logic           rom_ok = 1'b0;
  logic [AW-1:0]  start_addr, stop_addr;
  logic [3:0]     att;
  logic [CH-1:0]  start, stop;
  logic [CH-1:0]  busy = '0, ack = '0;
  logic           qfull, ovf;

  jt6295_ctrl_q #(.CH(CH), .PHW(PHW), .AW(AW), .QD(QD)) dut (
    .clk(clk), .rst(rst), .cen4(cen4), .wrn(wrn), .din(din),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .start_addr(start_addr), .stop_addr(stop_addr), .att(att),
    .start(start), .stop(stop), .busy(busy), .ack(ack),
    .qfull(qfull), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [7:0]    rom [0:(1<<(PHW+3))-1];
  int            n_chk = 0, n_pass = 0;
  bit            rand_ok = 0;
  int            mgrp = 0;
  logic [CH-1:0] mstop = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ROM responder: garbage flagged valid right after an address change, then real data
  initial begin
    logic [PHW+2:0] last;
    last = '0;
    forever begin
      @(posedge clk); #1;
      if (rom_addr != last) begin
        rom_ok   = 1'b1;
        rom_data = ~rom[rom_addr];
      end else begin
        rom_ok   = rand_ok ? 1'($urandom_range(0, 1)) : 1'b1;
        rom_data = rom_ok ? rom[rom_addr] : ~rom[rom_addr];
      end
      last = rom_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [AW-1:0] fld(input int ph, input int base);
    logic [23:0] v;
    v = {rom[ph*8+base], rom[ph*8+base+1], rom[ph*8+base+2]};
    return v[AW-1:0];
  endfunction

  function automatic logic [CH-1:0] chans(input logic [3:0] nib);
    logic [CH-1:0] t;
    t = CH'(nib);
    return t << (4 * mgrp);
  endfunction

  task automatic wr(input logic [7:0] b);
    din = b; wrn = 1'b0;
    @(posedge clk); #1;
    wrn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cmd_grp(input int g);
    wr(8'(g));
    mgrp = g % (CH / 4);
  endtask

  task automatic cmd_stop(input logic [3:0] n, input logic [2:0] junk);
    wr({1'b0, n, junk});
    mstop = mstop | chans(n);
  endtask

  task automatic cmd_start(input int ph, input logic [3:0] m, input logic [3:0] a,
                           output logic [CH-1:0] cm);
    wr(8'h80 | 8'(ph));
    wr({m, a});
    cm    = chans(m);
    mstop = mstop & ~cm;
  endtask

  task automatic wait_start(input int lim);
    int n;
    n = 0;
    while (start == '0 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_timeout", 32'(start != '0), 1);
  endtask

  task automatic chk_load(input int ph, input logic [CH-1:0] cm, input logic [3:0] a);
    check("ld_start", start, cm);
    check("ld_saddr", start_addr, fld(ph, 0));
    check("ld_eaddr", stop_addr, fld(ph, 3));
    check("ld_att", att, a);
  endtask

  task automatic ack_all();
    ack = '1;
    @(posedge clk); #1;
    ack = '0;
    check("ack_clear", start, 0);
  endtask

  task automatic cen4_pulse(input logic [CH-1:0] b);
    busy = b; cen4 = 1'b1;
    @(posedge clk); #1;
    cen4  = 1'b0;
    mstop = mstop & b;
    check("stop_retire", stop, mstop);
  endtask

  initial begin
    logic [CH-1:0] cm, pa;
    int ph [4];
    int n;
    for (int i = 0; i < (1 << (PHW+3)); i++) rom[i] = 8'($urandom);
    rom[40] = 8'h00; rom[41] = 8'h12; rom[42] = 8'h34;
    rom[43] = 8'h00; rom[44] = 8'h56; rom[45] = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_start", start, 0);
    check("rst_stop", stop, 0);
    check("rst_addr", start_addr | stop_addr, 0);
    check("rst_rom", rom_addr, 0);
    check("rst_flags", {qfull, ovf}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // latency and field assembly with rom_ok high
    wr(8'h85);
    din = 8'h2F; wrn = 1'b0;
    @(posedge clk); #1;
    wrn = 1'b1;
    n = 0;
    while (start == '0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t1_latency", n, 14);
    check("t1_start", start, 8'b0000_0010);
    check("t1_saddr", start_addr, 18'h01234);
    check("t1_eaddr", stop_addr, 18'h056FF);
    check("t1_att", att, 4'hF);
    ack = 8'h02;
    @(posedge clk); #1;
    ack = '0;
    check("t1_ack", start, 0);

    // stop set / retire, write wins over same-cycle cen4
    busy = '1;
    cmd_stop(4'b1001, 3'd0);
    check("t3_stop", stop, mstop);
    cen4_pulse(8'hFE);
    busy = 8'hF0; din = 8'h10; wrn = 1'b0; cen4 = 1'b1;
    @(posedge clk); #1;
    cen4 = 1'b0; wrn = 1'b1;
    mstop = (mstop & busy) | 8'h02;
    check("t3_win", stop, mstop);
    @(posedge clk); #1;
    cen4_pulse('0);

    // group select and stop cancelling a held start
    cmd_grp(1);
    cmd_start(1, 4'b0001, 4'hC, cm);
    wait_start(100);
    chk_load(1, cm, 4'hC);
    cmd_stop(4'b0001, 3'd0);
    check("t4_stop", stop, mstop);
    check("t4_cancel", start, 0);
    cen4_pulse('0);
    cmd_grp(0);

    // queue fill and overflow; queued entries load in order
    for (int k = 0; k < 4; k++) ph[k] = 16 + k;
    cmd_start(ph[0], 4'd1, 4'd1, cm);
    cmd_start(ph[1], 4'd2, 4'd2, cm);
    cmd_start(ph[2], 4'd4, 4'd3, cm);
    check("t2_qfull", qfull, 1);
    check("t2_noovf", ovf, 0);
    cmd_start(ph[3], 4'd8, 4'd4, cm);
    check("t2_ovf", ovf, 1);
    for (int k = 0; k < 3; k++) begin
      wait_start(200);
      chk_load(ph[k], chans(4'(1 << k)), 4'(k + 1));
      ack_all();
    end
    repeat (40) @(posedge clk);
    #1;
    check("t2_drained", start, 0);
    check("t2_qempty", qfull, 0);
    check("t2_sticky", ovf, 1);

    // random rom_ok pacing
    rand_ok = 1;
    cmd_start(5, 4'b0010, 4'hF, cm);
    wait_start(600);
    chk_load(5, cm, 4'hF);
    ack_all();

    // reset in the middle of a fetch
    rand_ok = 0;
    cmd_stop(4'b1000, 3'd0);
    cmd_start(5, 4'b0011, 4'h7, cm);
    n = 0;
    while (rom_addr[2:0] != 3'd3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_reach", rom_addr[2:0], 3);
    #2 rst = 1'b1;
    #1;
    check("t6_start", start, 0);
    check("t6_stop", stop, 0);
    check("t6_saddr", start_addr, 0);
    check("t6_eaddr", stop_addr, 0);
    check("t6_att", att, 0);
    check("t6_rom", rom_addr, 0);
    check("t6_flags", {qfull, ovf}, 0);
    @(posedge clk); #1;
    rst = 1'b0; mgrp = 0; mstop = '0;
    repeat (30) @(posedge clk);
    #1;
    check("t6_idle", {start, rom_addr}, 0);

    // randomized command mix against the model
    rand_ok = 1;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) != 2) begin
        if ($urandom_range(0, 1) == 1) cmd_grp($urandom_range(0, 7));
        n = $urandom_range(0, 127);
        cmd_start(n, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), cm);
        wait_start(600);
        check("r_start", start, cm);
        check("r_saddr", start_addr, fld(n, 0));
        check("r_eaddr", stop_addr, fld(n, 3));
        check("r_stop", stop, mstop);
        pa  = cm & CH'($urandom);
        ack = pa;
        @(posedge clk); #1;
        ack = '0;
        check("r_partial", start, cm & ~pa);
        ack_all();
      end else begin
        busy = '1;
        cmd_stop(4'($urandom_range(1, 15)), 3'($urandom));
        check("r_stopset", stop, mstop);
        cen4_pulse(CH'($urandom));
      end
    end
    check("r_noovf", ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
